// File: rtl/result_capture_fifo.sv
// Result capture FIFO: synchronizes an asynchronous upstream result handshake, buffers results in a
// small circular queue and shows the oldest entry on a registered seven-segment display.
module result_capture_fifo #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] res_in,
  input  logic       rdy_in,
  input  logic       proc_in,
  input  logic       pop_in,
  input  logic       clr_in,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] cnt_out,
  output logic       empty_out,
  output logic       full_out,
  output logic       ovf_out
);

  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntFull = 4'(DEPTH);
  localparam logic [6:0]  SegDash = 7'b1000000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [SYNC_STAGES-1:0]      rdy_sync_q, proc_sync_q;
  logic [SYNC_STAGES-1:0][3:0] res_sync_q;
  logic                        rdy_prev_q, pop_prev_q;
  logic [PtrW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;
  logic                        empty_q, full_q;
  logic [6:0]                  seg_q, seg_d;
  logic [3:0]                  mem_q [DEPTH];

  logic       rdy_s;
  logic [3:0] res_s;
  logic       push_req, pop_req, push_ok, pop_ok;
  logic [3:0] head_nxt;

  assign rdy_s    = rdy_sync_q[SYNC_STAGES-1];
  assign res_s    = res_sync_q[SYNC_STAGES-1];
  assign push_req = rdy_s & ~rdy_prev_q;
  assign pop_req  = pop_in & ~pop_prev_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    if (clr_in) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      pop_ok  = pop_req & ~empty_q;
      // A simultaneous pop frees the slot, so a push into a full queue still lands.
      push_ok = push_req & (~full_q | pop_ok);
      if (push_req && full_q && !pop_ok) ovf_d = 1'b1;
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + 4'(push_ok) - 4'(pop_ok);
    end
    // The new head may be the slot written on this very edge.
    head_nxt = (push_ok && (wptr_q == rptr_d)) ? res_s : mem_q[rptr_d];
    seg_d    = (cnt_d == 4'd0) ? SegDash : hex_to_seg(head_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_sync_q  <= '0;
      proc_sync_q <= '0;
      res_sync_q  <= '0;
      rdy_prev_q  <= 1'b0;
      pop_prev_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      seg_q       <= SegDash;
    end else begin
      rdy_sync_q  <= {rdy_sync_q[SYNC_STAGES-2:0], rdy_in};
      proc_sync_q <= {proc_sync_q[SYNC_STAGES-2:0], proc_in};
      res_sync_q  <= {res_sync_q[SYNC_STAGES-2:0], res_in};
      rdy_prev_q  <= rdy_s;
      pop_prev_q  <= pop_in;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      empty_q     <= (cnt_d == 4'd0);
      full_q      <= (cnt_d == CntFull);
      seg_q       <= seg_d;
    end
  end

  // Storage is never visible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= res_s;
  end

  assign seg_out   = seg_q;
  assign dp_out    = proc_sync_q[SYNC_STAGES-1];
  assign cnt_out   = cnt_q;
  assign empty_out = empty_q;
  assign full_out  = full_q;
  assign ovf_out   = ovf_q;

endmodule

// File: doc/result_capture_fifo.md
RESULT_CAPTURE_FIFO -- requirements
Module: result_capture_fifo

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of result entries (power of two, 2..8).
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the flop count of each input synchronizer (>=2).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 res_in  input  4  result nibble from the upstream processing block; stable while rdy_in is high.
REQ-007 rdy_in  input  1  upstream result-ready; asynchronous to clk.
REQ-008 proc_in  input  1  upstream processing-busy; asynchronous to clk.
REQ-009 pop_in  input  1  advance-display request, synchronous to clk, level input, edge-detected.
REQ-010 clr_in  input  1  synchronous flush, synchronous to clk.
REQ-011 seg_out  output  7  seven-segment drive, bit0=a .. bit6=g, active high.
REQ-012 dp_out  output  1  synchronized proc_in (busy indicator).
REQ-013 cnt_out  output  4  entries held, 0..DEPTH.
REQ-014 empty_out / full_out / ovf_out  output  1 each  cnt==0, cnt==DEPTH, sticky overflow.

Function
REQ-015 rdy_in, proc_in and all 4 bits of res_in SHALL each pass through a SYNC_STAGES-deep flop chain; no other logic SHALL sample them.
REQ-016 A push SHALL occur on the clock edge where synchronized rdy is 1 and its previous registered value is 0 (rising edge only; a held-high rdy_in pushes once).
REQ-017 The pushed value SHALL be synchronized res_in at that same edge; cnt_out SHALL reflect the push SYNC_STAGES+1 clock edges after rdy_in rises.
REQ-018 A pop SHALL occur on the clock edge where pop_in is 1 and its previous registered value was 0.
REQ-019 Storage SHALL be a circular buffer with write and read pointers incrementing modulo DEPTH.
REQ-020 Push when full (without pop) SHALL discard the new value, leave contents/count unchanged and set ovf_out.
REQ-021 Pop when empty SHALL be ignored; no state change, no flag set.
REQ-022 Simultaneous push and pop when 0<cnt<DEPTH SHALL perform both; cnt unchanged.
REQ-023 Simultaneous push and pop when empty SHALL perform push only; cnt becomes 1.
REQ-024 Simultaneous push and pop when full SHALL perform both; cnt stays DEPTH; ovf_out not set.
REQ-025 clr_in high SHALL, on that edge, zero both pointers and cnt and clear ovf_out, overriding any push or pop on the same edge.
REQ-026 ovf_out SHALL stay set until clr_in or rst_n.
REQ-027 seg_out SHALL be registered: when not empty, hex decode (0-9, A, b, C, d, E, F) of the head (oldest) entry; when empty, dash 7'b1000000.
REQ-028 seg_out SHALL update on the edge after any push, pop or clear that changes the head or emptiness (one-cycle latency).
REQ-029 dp_out SHALL equal the final flop of the proc_in synchronizer.
REQ-030 empty_out, full_out, cnt_out SHALL be registered and mutually consistent every cycle.

Reset
REQ-031 rst_n low SHALL immediately force: cnt_out=0, empty_out=1, full_out=0, ovf_out=0, dp_out=0, seg_out=7'b1000000, pointers 0, all synchronizer and edge-history flops 0.
REQ-032 Storage contents need not be reset; they SHALL never be visible while empty.
REQ-033 If rdy_in is high when rst_n deasserts, exactly one push SHALL occur after SYNC_STAGES+1 edges.
REQ-034 Reset asserted mid-operation SHALL discard all entries and the overflow flag.

Verification
REQ-035 Reset release, rdy_in pulse with res_in=4'hA -> cnt_out=1 after 3 edges, seg_out=A decode (7'b1110111), empty_out=0.
REQ-036 Push 3,5,7,9 then a fifth value 1 -> full_out=1, ovf_out=1, cnt_out=4; four pops show 3,5,7,9 in order, then dash, empty_out=1.
REQ-037 Hold rdy_in high 20 cycles -> exactly one push; hold pop_in high 20 cycles -> exactly one pop.
REQ-038 With cnt=4, push 2 and pop on the same edge -> cnt_out stays 4, ovf_out=0, head advances; with cnt=0, same event -> cnt_out=1, seg_out shows the pushed value.
REQ-039 clr_in on the same edge as a push, with ovf_out=1 -> cnt_out=0, ovf_out=0, seg_out=dash.
REQ-040 rst_n pulsed low for less than one clock period with cnt=2, between clock edges -> all outputs at reset values immediately, no clock required.
